// File: rtl/common.sv
// Shared sizing helpers and handshake types for the streaming blocks.
// clog2/bits are constant functions so they can size ports and localparams.
package common;

  // Both sides of the FIFO can fire on the same edge; this names the four cases.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

  // Bits needed to hold the value itself (so DEPTH fits in the count).
  function automatic int bits(input int value);
    int result;
    result = clog2(value + 1);
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Storage for stream_fifo: register array with a synchronous write port and an
// asynchronous read port, kept apart so it can be swapped for distributed RAM.
module stream_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are intentionally not reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_fifo.sv
// Single-clock valid/ready FIFO of arbitrary depth with first-word fall-through.
// Pointers wrap explicitly at DEPTH-1, so non-power-of-two depths work.
module stream_fifo
  import common::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [bits(DEPTH)-1:0] count,
  output logic                   almost_full
);

  localparam int PTR_W = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1;
  localparam int CNT_W = bits(DEPTH);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);

  typedef logic [DATA_W-1:0] data_t;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  data_t            head_data;
  fifo_op_e         op;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Flags come only from the registered count, so in_ready never sees out_ready.
  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign almost_full = (count >= AFULL_CNT);

  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign out_data = head_data;

  always_comb begin
    op = OP_IDLE;
    case ({push, pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
    end
  end

  // A simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case (op)
        OP_PUSH: count <= count + CNT_W'(1);
        OP_POP:  count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  stream_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (head_data)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo: a DEPTH=16 and a DEPTH=5 instance are driven
// side by side and compared against a queue-based reference model.
module tb_stream_fifo;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic       in_valid16, in_ready16, out_valid16, out_ready16, almost_full16;
  logic [7:0] in_data16, out_data16;
  logic [4:0] count16;

  logic       in_valid5, in_ready5, out_valid5, out_ready5, almost_full5;
  logic [7:0] in_data5, out_data5;
  logic [2:0] count5;

  int checks   = 0;
  int failures = 0;

  bit         mon_en = 1'b0;
  int         model_count [2];
  int         dut_pops [2];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];

  stream_fifo #(.DATA_W(8), .DEPTH(16), .AFULL_LVL(12)) dut16 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid16),
    .in_ready    (in_ready16),
    .in_data     (in_data16),
    .out_valid   (out_valid16),
    .out_ready   (out_ready16),
    .out_data    (out_data16),
    .count       (count16),
    .almost_full (almost_full16)
  );

  stream_fifo #(.DATA_W(8), .DEPTH(5), .AFULL_LVL(4)) dut5 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid5),
    .in_ready    (in_ready5),
    .in_data     (in_data5),
    .out_valid   (out_valid5),
    .out_ready   (out_ready5),
    .out_data    (out_data5),
    .count       (count5),
    .almost_full (almost_full5)
  );

  function automatic int depth_of(input int i);
    return (i == 0) ? 16 : 5;
  endfunction

  function automatic int afull_of(input int i);
    return (i == 0) ? 12 : 4;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one instance for the coming edge and records what the model says it accepts.
  task automatic applyStimulus(input int i, input logic v, input logic [7:0] d, input logic r);
    if (i == 0) begin
      in_valid16 = v; in_data16 = d; out_ready16 = r;
    end else begin
      in_valid5 = v; in_data5 = d; out_ready5 = r;
    end
    if (v && model_count[i] < depth_of(i)) begin
      if (i == 0) exp_q0.push_back(d);
      else        exp_q1.push_back(d);
    end
  endtask

  // Compares one instance against the model, then advances the model across the edge.
  task automatic checkOutput(input int i);
    int         mc, depth, cnt, qsize;
    logic       ir, ov, af, iv, orr;
    logic [7:0] od, head;
    bit         do_push, do_pop;
    mc    = model_count[i];
    depth = depth_of(i);
    if (i == 0) begin
      ir = in_ready16; ov = out_valid16; af = almost_full16; od = out_data16;
      cnt = int'(count16); iv = in_valid16; orr = out_ready16; qsize = exp_q0.size();
      head = (qsize > 0) ? exp_q0[0] : 8'h00;
    end else begin
      ir = in_ready5; ov = out_valid5; af = almost_full5; od = out_data5;
      cnt = int'(count5); iv = in_valid5; orr = out_ready5; qsize = exp_q1.size();
      head = (qsize > 0) ? exp_q1[0] : 8'h00;
    end
    check($sformatf("count_d%0d", depth), cnt, mc);
    check($sformatf("count_range_d%0d", depth), int'(cnt <= depth), 1);
    check($sformatf("in_ready_d%0d", depth), int'(ir), int'(mc != depth));
    check($sformatf("out_valid_d%0d", depth), int'(ov), int'(mc != 0));
    check($sformatf("almost_full_d%0d", depth), int'(af), int'(mc >= afull_of(i)));
    if (mc != 0) begin
      if (qsize == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard_d%0d: got data %02h expected none queued", depth, od);
      end else begin
        check($sformatf("data_d%0d", depth), int'(od), int'(head));
      end
    end
    if (ov && orr) dut_pops[i]++;
    do_push = iv && (mc < depth);
    do_pop  = orr && (mc > 0);
    if (do_pop && qsize > 0) begin
      if (i == 0) void'(exp_q0.pop_front());
      else        void'(exp_q1.pop_front());
    end
    model_count[i] = mc + int'(do_push) - int'(do_pop);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        checkOutput(0);
        checkOutput(1);
      end
    end
  end

  task automatic step(input logic v0, input logic [7:0] d0, input logic r0,
                      input logic v1, input logic [7:0] d1, input logic r1);
    @(negedge clk);
    applyStimulus(0, v0, d0, r0);
    applyStimulus(1, v1, d1, r1);
  endtask

  task automatic step16(input logic v, input logic [7:0] d, input logic r);
    step(v, d, r, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_in_ready16"}, int'(in_ready16), 1);
    check({tag, "_out_valid16"}, int'(out_valid16), 0);
    check({tag, "_count16"}, int'(count16), 0);
    check({tag, "_almost_full16"}, int'(almost_full16), 0);
    check({tag, "_in_ready5"}, int'(in_ready5), 1);
    check({tag, "_out_valid5"}, int'(out_valid5), 0);
    check({tag, "_count5"}, int'(count5), 0);
    check({tag, "_almost_full5"}, int'(almost_full5), 0);
  endtask

  task automatic idleInputs();
    in_valid16 = 1'b0; in_data16 = 8'h00; out_ready16 = 1'b0;
    in_valid5  = 1'b0; in_data5  = 8'h00; out_ready5  = 1'b0;
  endtask

  initial begin
    int p0;
    rst_n = 1'b0;
    idleInputs();
    model_count[0] = 0; model_count[1] = 0;
    dut_pops[0] = 0; dut_pops[1] = 0;
    repeat (2) @(negedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("[TB] fill DEPTH=16, overflow attempt, push/pop at full");
    for (int k = 1; k <= 16; k++) step16(1'b1, 8'(k), 1'b0);
    step16(1'b1, 8'hFF, 1'b0);
    #3;
    check("full_count", int'(count16), 16);
    check("full_in_ready", int'(in_ready16), 0);
    check("full_almost_full", int'(almost_full16), 1);
    step16(1'b1, 8'h77, 1'b1);
    step16(1'b1, 8'h88, 1'b0);
    #3;
    check("full_pushpop_count", int'(count16), 15);
    step16(1'b0, 8'h00, 1'b0);
    #3;
    check("refill_count", int'(count16), 16);
    repeat (20) step16(1'b0, 8'h00, 1'b1);
    step16(1'b0, 8'h00, 1'b0);

    $display("[TB] fall-through latency");
    step16(1'b1, 8'hA5, 1'b0);
    step16(1'b0, 8'h00, 1'b0);
    #3;
    check("fwft_out_valid", int'(out_valid16), 1);
    check("fwft_out_data", int'(out_data16), 8'hA5);
    step16(1'b0, 8'h00, 1'b1);
    step16(1'b0, 8'h00, 1'b0);
    #3;
    check("fwft_empty_count", int'(count16), 0);
    check("fwft_empty_valid", int'(out_valid16), 0);

    $display("[TB] steady push/pop at count 3");
    for (int k = 0; k < 3; k++) step16(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    p0 = dut_pops[0];
    repeat (20) step16(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    step16(1'b0, 8'h00, 1'b0);
    #3;
    check("steady_pops", dut_pops[0] - p0, 20);
    check("steady_count", int'(count16), 3);

    $display("[TB] random traffic on both instances");
    for (int c = 0; c < 1000; c++) begin
      int pv, pr;
      case ((c / 100) % 3)
        0:       begin pv = 75; pr = 25; end
        1:       begin pv = 25; pr = 75; end
        default: begin pv = 50; pr = 50; end
      endcase
      step(1'($urandom_range(0, 99) < pv), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 99) < pr),
           1'($urandom_range(0, 99) < pv), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 99) < pr));
    end
    for (int k = 0; k < 4; k++) step(1'b1, 8'(k), 1'b0, 1'b1, 8'(k), 1'b0);

    $display("[TB] asynchronous reset mid-run");
    @(negedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkResetValues("midreset");
    exp_q0.delete();
    exp_q1.delete();
    model_count[0] = 0;
    model_count[1] = 0;
    idleInputs();
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b1, 8'hC3, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #3;
    mon_en = 1'b0;
    check("final_q16_empty", exp_q0.size(), 0);
    check("final_q5_empty", exp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
